fft_2d_seq: RTL and testbench

FFT_2D_SEQ -- requirements
Module: fft_2d_seq

---
 rtl/fft2d_pkg.sv | 26 ++
 rtl/fft2d_tbuf.sv | 35 +++
 rtl/fft_2d_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_fft_2d_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft2d_pkg.sv
// Shared types for the 2-D FFT sequencer: FSM state encoding, the complex
// sample layout used at the default width, and the counter-width helper.
package fft2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW_FEED,
    ROW_WAIT,
    COL_FEED,
    COL_WAIT,
    OUT
  } state_t;

  // Complex sample at the default 64-bit width: real in the upper half.
  localparam int CPLX_W = 64;
  typedef struct packed {
    logic [CPLX_W/2-1:0] re;
    logic [CPLX_W/2-1:0] im;
  } cplx_t;

  // Bits needed to index 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft2d_tbuf.sv
// Transpose buffer: N_POINT x N_POINT sample array with one synchronous
// write port and one combinational read port, both addressed by (row, col).
module fft2d_tbuf
  import fft2d_pkg::*;
#(
  parameter int N_POINT = 8,
  parameter int DW      = 64,
  localparam int AW     = cnt_w(N_POINT)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_row,
  input  logic [AW-1:0] i_wr_col,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_row,
  input  logic [AW-1:0] i_rd_col,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [N_POINT][N_POINT];

  // Store one sample per cycle at (row, col).
  // NOTE: the array has no reset -- every location is written by the row pass
  // before anything reads it, so clearing it would only add reset fan-out.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_row][i_rd_col];

endmodule

// File: rtl/fft_2d_seq.sv
// 2-D FFT sequencer: streams a row-major N_POINT x N_POINT frame through an
// external 1-D FFT core, first along rows, then along columns of the
// transpose buffer, then streams the result out row-major. No arithmetic is
// done here; samples pass through at full width.
// Optional macro FFT2D_INV_EN adds an inv input latched per frame and a
// c_cfg_inv output that tells the core to run the inverse transform.
module fft_2d_seq
  import fft2d_pkg::*;
#(
  parameter int N_POINT = 8,
  parameter int DW      = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          c_in_valid,
  input  logic          c_in_ready,
  output logic [DW-1:0] c_in_data,
  output logic          c_in_last,
  input  logic          c_out_valid,
  input  logic [DW-1:0] c_out_data,
  input  logic          c_out_last,
  output logic          busy,
  output logic          err
`ifdef FFT2D_INV_EN
  ,
  input  logic          inv,
  output logic          c_cfg_inv
`endif
);

  localparam int            AW       = cnt_w(N_POINT);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINT - 1);

  state_t        r_state;
  logic [AW-1:0] r_row;    // row pass index, then output row
  logic [AW-1:0] r_col;    // column pass index, then output column
  logic [AW-1:0] r_idx;    // beat index within the current 1-D pass
  logic          r_err;
  logic          r_flush;  // core results still in flight from before reset

  logic          w_in_hs;
  logic          w_first;
  logic          w_frame_bad;
  logic          w_wait;
  logic          w_beat_ok;
  logic          w_beat_bad;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_row;
  logic [AW-1:0] w_wr_col;
  logic [AW-1:0] w_rd_row;
  logic [AW-1:0] w_rd_col;
  logic [DW-1:0] w_rd_data;

  assign w_in_hs     = (r_state == ROW_FEED) && s_valid && c_in_ready;
  assign w_first     = (r_row == '0) && (r_idx == '0);
  // Framing follows the sample count only; s_last is just cross-checked.
  assign w_frame_bad = w_in_hs && (s_last != ((r_row == LAST_IDX) && (r_idx == LAST_IDX)));

  assign w_wait      = (r_state == ROW_WAIT) || (r_state == COL_WAIT);
  assign w_beat_ok   = c_out_valid && w_wait && (!c_out_last || (r_idx == LAST_IDX));
  assign w_beat_bad  = c_out_valid &&
                       ((w_wait && c_out_last && (r_idx != LAST_IDX)) ||
                        (!w_wait && !r_flush));

  // Row results land along the row; column results are written back in place.
  assign w_wr_en  = w_beat_ok;
  assign w_wr_row = (r_state == ROW_WAIT) ? r_row : r_idx;
  assign w_wr_col = (r_state == ROW_WAIT) ? r_idx : r_col;
  assign w_rd_row = (r_state == COL_FEED) ? r_idx : r_row;
  assign w_rd_col = r_col;

  fft2d_tbuf #(
    .N_POINT (N_POINT),
    .DW      (DW)
  ) u_tbuf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_row  (w_wr_row),
    .i_wr_col  (w_wr_col),
    .i_wr_data (c_out_data),
    .i_rd_row  (w_rd_row),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data)
  );

  // Main sequencer: row passes, column passes, then row-major readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_flush <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_state <= ROW_FEED;
            r_row   <= '0;
            r_col   <= '0;
            r_idx   <= '0;
          end
        end
        ROW_FEED: begin
          if (w_in_hs) begin
            r_flush <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= ROW_WAIT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ROW_WAIT: begin
          if (w_beat_ok) begin
            if (c_out_last) begin
              r_idx <= '0;
              if (r_row == LAST_IDX) begin
                r_row   <= '0;
                r_col   <= '0;
                r_state <= COL_FEED;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= ROW_FEED;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        COL_FEED: begin
          if (c_in_ready) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= COL_WAIT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        COL_WAIT: begin
          if (w_beat_ok) begin
            if (c_out_last) begin
              r_idx <= '0;
              if (r_col == LAST_IDX) begin
                r_row   <= '0;
                r_col   <= '0;
                r_state <= OUT;
              end else begin
                r_col   <= r_col + 1'b1;
                r_state <= COL_FEED;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            if (r_col == LAST_IDX) begin
              r_col <= '0;
              if (r_row == LAST_IDX) begin
                r_row   <= '0;
                r_state <= IDLE;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky error: set by framing or core protocol faults, cleared by a clean
  // first sample of the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_frame_bad || w_beat_bad) begin
      r_err <= 1'b1;
    end else if (w_in_hs && w_first) begin
      r_err <= 1'b0;
    end
  end

  // Stream outputs decoded from the registered state and counters.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    s_ready    = 1'b0;
    c_in_valid = 1'b0;
    c_in_data  = '0;
    c_in_last  = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    case (r_state)
      ROW_FEED: begin
        s_ready    = c_in_ready;
        c_in_valid = s_valid;
        c_in_data  = s_data;
        c_in_last  = (r_idx == LAST_IDX);
      end
      COL_FEED: begin
        c_in_valid = 1'b1;
        c_in_data  = w_rd_data;
        c_in_last  = (r_idx == LAST_IDX);
      end
      OUT: begin
        m_valid = 1'b1;
        m_data  = w_rd_data;
        m_last  = (r_row == LAST_IDX) && (r_col == LAST_IDX);
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign err  = r_err;

`ifdef FFT2D_INV_EN
  logic r_inv;

  // Direction is captured once per frame so the core sees a stable setting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv <= 1'b0;
    end else if ((r_state == IDLE) && s_valid) begin
      r_inv <= inv;
    end
  end

  assign c_cfg_inv = r_inv;
`endif

endmodule

// File: tb/tb_fft_2d_seq.sv
// Bench for fft_2d_seq with N_POINT=8: an ideal 1-D DFT core (about ten
// cycles of latency) closes the loop, a direct 2-D DFT of each frame fills a
// scoreboard queue, and a negedge monitor pops and compares every output.
module tb_fft_2d_seq;
  import fft2d_pkg::*;

  localparam int  N  = 8;
  localparam int  NN = N * N;
  localparam int  DW = 64;
  localparam real PI = 3.14159265358979;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          c_in_valid, c_in_ready, c_in_last;
  logic [DW-1:0] c_in_data;
  logic          c_out_valid = 1'b0;
  logic [DW-1:0] c_out_data  = '0;
  logic          c_out_last  = 1'b0;
  logic          busy, err;
  logic          core_inv;
`ifdef FFT2D_INV_EN
  logic          inv = 1'b0;
  logic          c_cfg_inv;
  assign core_inv = c_cfg_inv;
`else
  assign core_inv = 1'b0;
`endif

  fft_2d_seq #(.N_POINT(N), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .c_in_valid  (c_in_valid),
    .c_in_ready  (c_in_ready),
    .c_in_data   (c_in_data),
    .c_in_last   (c_in_last),
    .c_out_valid (c_out_valid),
    .c_out_data  (c_out_data),
    .c_out_last  (c_out_last),
    .busy        (busy),
    .err         (err)
`ifdef FFT2D_INV_EN
    ,
    .inv         (inv),
    .c_cfg_inv   (c_cfg_inv)
`endif
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] frame[NN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [DW-1:0] pk(input int re, input int im);
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

  function automatic int re_of(input logic [DW-1:0] d);
    cplx_t c;
    c = d;
    return int'(signed'(c.re));
  endfunction

  function automatic int im_of(input logic [DW-1:0] d);
    cplx_t c;
    c = d;
    return int'(signed'(c.im));
  endfunction

  // ---------------- ideal 1-D core model ----------------
  int            core_re[N];
  int            core_im[N];
  logic [DW-1:0] core_res[N];
  int            core_icnt = 0, core_dly = 0, core_ocnt = 0, core_lasts = 0;
  logic          core_calc = 1'b0, core_emit = 1'b0;

  function automatic logic [DW-1:0] core_dft(input int k);
    real sr, si, th, sg;
    sr = 0.0;
    si = 0.0;
    sg = core_inv ? -1.0 : 1.0;
    for (int n = 0; n < N; n++) begin
      th = 2.0 * PI * real'(k * n) / real'(N);
      sr += real'(core_re[n]) * $cos(th) + sg * real'(core_im[n]) * $sin(th);
      si += real'(core_im[n]) * $cos(th) - sg * real'(core_re[n]) * $sin(th);
    end
    return pk(rnd(sr), rnd(si));
  endfunction

  always @(posedge clk) begin
    c_out_valid <= 1'b0;
    c_out_last  <= 1'b0;
    if (rst) begin
      core_icnt <= 0;
      core_calc <= 1'b0;
      core_dly  <= 0;
      core_emit <= 1'b0;
      core_ocnt <= 0;
    end else begin
      core_calc <= 1'b0;
      if (c_in_valid && c_in_ready) begin
        core_re[core_icnt] <= re_of(c_in_data);
        core_im[core_icnt] <= im_of(c_in_data);
        core_icnt <= c_in_last ? 0 : core_icnt + 1;
        if (c_in_last) core_calc <= 1'b1;
      end
      if (core_calc) begin
        for (int k = 0; k < N; k++) core_res[k] <= core_dft(k);
        core_dly <= 8;
      end else if (core_dly > 0) begin
        core_dly <= core_dly - 1;
        if (core_dly == 1) begin
          core_emit <= 1'b1;
          core_ocnt <= 0;
        end
      end
      if (core_emit) begin
        c_out_valid <= 1'b1;
        c_out_data  <= core_res[core_ocnt];
        c_out_last  <= (core_ocnt == N - 1);
        core_ocnt   <= core_ocnt + 1;
        if (core_ocnt == N - 1) begin
          core_emit  <= 1'b0;
          core_lasts <= core_lasts + 1;
        end
      end
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            out_idx = 0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      if (prev_stall) begin
        check($sformatf("hold_data[%0d]", out_idx), m_data, prev_data);
        check($sformatf("hold_last[%0d]", out_idx), m_last, prev_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        n_tests++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL out_extra: observed output %h, expected none", m_data);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("m_data[%0d]", out_idx), m_data, e);
          check($sformatf("m_last[%0d]", out_idx), m_last, exp_q.size() == 0);
          out_idx = (exp_q.size() == 0) ? 0 : out_idx + 1;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_expected();
    real sr, si, th;
    int  xr, xi;
    for (int k = 0; k < N; k++) begin
      for (int l = 0; l < N; l++) begin
        sr = 0.0;
        si = 0.0;
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            xr = re_of(frame[r*N+c]);
            xi = im_of(frame[r*N+c]);
            th = 2.0 * PI * real'(k * r + l * c) / real'(N);
            sr += real'(xr) * $cos(th) + real'(xi) * $sin(th);
            si += real'(xi) * $cos(th) - real'(xr) * $sin(th);
          end
        end
        exp_q.push_back(pk(rnd(sr), rnd(si)));
      end
    end
  endtask

  // Period-4 tile keeps every 1-D and 2-D transform integer-exact.
  task automatic make_tile();
    int tr[16], ti[16];
    for (int i = 0; i < 16; i++) begin
      tr[i] = int'($urandom_range(0, 100)) - 50;
      ti[i] = int'($urandom_range(0, 100)) - 50;
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        frame[r*N+c] = pk(tr[(r%4)*4 + (c%4)], ti[(r%4)*4 + (c%4)]);
  endtask

  task automatic send_frame(input string tag, input int bad_pos);
    logic rdy;
    int   guard;
    for (int i = 0; i < NN; i++) begin
      s_valid = 1'b1;
      s_data  = frame[i];
      s_last  = (bad_pos >= 0) ? (i == bad_pos) : (i == NN - 1);
      guard   = 0;
      do begin
        @(negedge clk);
        rdy = s_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!rdy && guard < 200);
      n_tests++;
      assert (rdy) else begin
        n_fail++;
        $error("FAIL %s_accept[%0d]: observed s_ready %b expected 1", tag, i, rdy);
      end
      if (!rdy) break;
      if (i == 0 && bad_pos != 0) check({tag, "_err_clear"}, err, 1'b0);
      if (i == bad_pos) check({tag, "_err_set"}, err, 1'b1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input bit stall);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
      m_ready = stall ? ~m_ready : 1'b1;
    end
    m_ready = 1'b1;
    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_drain: observed %0d outputs pending expected 0", tag, exp_q.size());
    end
    exp_q.delete();
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_mvalid_end"}, m_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    int base;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    m_ready    = 1'b1;
    c_in_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_c_in_valid", c_in_valid, 1'b0);
    check("rst_c_in_last", c_in_last, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Impulse at x[0][0] -> flat spectrum of ones.
    for (int i = 0; i < NN; i++) frame[i] = (i == 0) ? pk(1, 0) : pk(0, 0);
    push_expected();
    send_frame("impulse", -1);
    wait_drain("impulse", 1'b0);
    check("impulse_err", err, 1'b0);

    // Constant 1+0j -> single DC bin of 64.
    for (int i = 0; i < NN; i++) frame[i] = pk(1, 0);
    push_expected();
    send_frame("const", -1);
    wait_drain("const", 1'b0);

    // Mixed tile, without and then with output backpressure.
    make_tile();
    push_expected();
    send_frame("tile", -1);
    wait_drain("tile", 1'b0);
    push_expected();
    send_frame("stall", -1);
    wait_drain("stall", 1'b1);

    // s_last on sample 10: error flagged, frame still completes.
    push_expected();
    send_frame("badlast", 9);
    wait_drain("badlast", 1'b0);
    check("badlast_err_sticky", err, 1'b1);

    // Next clean frame clears the error on its first sample.
    for (int i = 0; i < NN; i++) frame[i] = (i == 0) ? pk(1, 0) : pk(0, 0);
    push_expected();
    send_frame("recover", -1);
    wait_drain("recover", 1'b0);
    check("recover_err", err, 1'b0);

    // Reset during the fourth column pass.
    for (int i = 0; i < NN; i++) frame[i] = pk(1, 0);
    base = core_lasts;
    send_frame("midrst", -1);
    guard = 0;
    while (core_lasts < base + N + 3 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_tests++;
    assert (core_lasts >= base + N + 3) else begin
      n_fail++;
      $error("FAIL midrst_reach_col3: observed %0d core passes expected %0d", core_lasts - base, N + 3);
    end
    repeat (2) @(posedge clk);
    #1;
    check("midrst_in_col_feed", c_in_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_c_in_valid", c_in_valid, 1'b0);
    check("midrst_c_in_last", c_in_last, 1'b0);
    check("midrst_c_in_data", c_in_data, '0);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_data", m_data, '0);
    check("midrst_s_ready", s_ready, 1'b0);
    check("midrst_err", err, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // A full frame after the mid-frame reset.
    make_tile();
    push_expected();
    send_frame("post_rst", -1);
    wait_drain("post_rst", 1'b0);
    check("post_rst_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
